// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM self-test: FSM states, March C- elements and the per-element op table.
package sram_bist_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

   typedef struct packed {
      logic down;     // walk addresses high to low
      logic rd_inv;   // read expects ~BG
      logic wr_inv;   // write stores ~BG
      logic has_rd;
      logic has_wr;
   } elem_cfg_t;

   // March C- (10n): the four middle elements do a read then a write at each address.
   function automatic elem_cfg_t elem_cfg(elem_t e);
      case (e)
         M0:      return '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
         M1:      return '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
         M2:      return '{down: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
         M3:      return '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
         M4:      return '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
         M5:      return '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Single-port SRAM bus driven by the BIST engine; read data returns one cycle after the address.
interface sram_bist_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport master (output mem_we, output mem_addr, output mem_din, input  mem_dout);
   modport slave  (input  mem_we, input  mem_addr, input  mem_din, output mem_dout);
endinterface

// File: rtl/bist_addr_gen.sv
// Up/down address counter: load jumps to the first address of the requested direction,
// step moves one address, last flags the final address of the current direction.
module bist_addr_gen #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              load_down,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_down ? ADDR_MAX : '0;
      end else if (step) begin
         addr <= down ? addr - ADDR_ONE : addr + ADDR_ONE;
      end
   end

   assign last = down ? (addr == '0) : (addr == ADDR_MAX);
endmodule

// File: rtl/sram_bist.sv
// March C- self-test of a single-port SRAM: one op per cycle, read data compared one cycle
// later in a stage overlapping the next op; the first mismatch address and data are kept.
module sram_bist
   import sram_bist_pkg::*;
#(
   parameter int                ADDR_W = 3,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] BG     = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   sram_bist_if.master       mem,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);
   state_t            state, state_nxt;
   elem_t             elem;
   elem_cfg_t         cfg, cfg_nxt;
   logic              phase;
   logic              go, is_rd, adv_addr, elem_end, last;
   logic [ADDR_W-1:0] addr, cmp_addr;
   logic              cmp_vld;
   logic [DATA_W-1:0] cmp_exp;

   assign go       = start && (state == S_IDLE || state == S_DONE);
   assign is_rd    = cfg.has_rd && !phase;
   // An address is finished after its write, or after its read when the element has no write.
   assign adv_addr = (state == S_RUN) && !(is_rd && cfg.has_wr);
   assign elem_end = adv_addr && last;
   assign cfg_nxt  = go ? elem_cfg(M0) : elem_cfg(elem_t'(elem + 3'd1));

   bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (go || elem_end),
      .load_down (cfg_nxt.down),
      .step      (adv_addr),
      .down      (cfg.down),
      .addr      (addr),
      .last      (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
         S_RUN:          if (elem_end && elem == M5) state_nxt = S_DRAIN;
         S_DRAIN:        state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_we   = 1'b0;
      mem.mem_addr = '0;
      mem.mem_din  = '0;
      busy         = (state == S_RUN) || (state == S_DRAIN);
      done         = (state == S_DONE);
      if (state == S_RUN) begin
         mem.mem_addr = addr;
         if (!is_rd) begin
            mem.mem_we  = 1'b1;
            mem.mem_din = cfg.wr_inv ? ~BG : BG;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem  <= M0;
         phase <= 1'b0;
         cfg   <= '0;
      end else if (go) begin
         elem  <= M0;
         phase <= 1'b0;
         cfg   <= cfg_nxt;
      end else if (state == S_RUN) begin
         phase <= is_rd && cfg.has_wr;
         if (elem_end && elem != M5) begin
            elem <= elem_t'(elem + 3'd1);
            cfg  <= cfg_nxt;
         end
      end
   end

   // Expected value is captured with the read so a same-address write next cycle cannot affect it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_vld   <= 1'b0;
         cmp_exp   <= '0;
         cmp_addr  <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
      end else begin
         cmp_vld  <= (state == S_RUN) && is_rd;
         cmp_exp  <= cfg.rd_inv ? ~BG : BG;
         cmp_addr <= addr;
         if (go) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
         end else if (cmp_vld && mem.mem_dout != cmp_exp && !fail) begin
            fail      <= 1'b1;
            fail_addr <= cmp_addr;
            fail_data <= mem.mem_dout;
         end
      end
   end
endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural SRAM with injectable faults and a march reference model.
module tb_sram_bist;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start0, start1;
   logic busy0, done0, fail0, busy1, done1, fail1;
   logic [2:0] fa0, fa1;
   logic [7:0] fd0, fd1;

   sram_bist_if #(.ADDR_W(3), .DATA_W(8)) b0 ();
   sram_bist_if #(.ADDR_W(3), .DATA_W(8)) b1 ();

   sram_bist #(.ADDR_W(3), .DATA_W(8), .BG(8'h00)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .mem(b0), .busy(busy0), .done(done0),
      .fail(fail0), .fail_addr(fa0), .fail_data(fd0));
   sram_bist #(.ADDR_W(3), .DATA_W(8), .BG(8'h55)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mem(b1), .busy(busy1), .done(done1),
      .fail(fail1), .fail_addr(fa1), .fail_data(fd1));

   // Fault knobs: a stuck-at bit on one cell, and a coupling fault (write @2 flips bit 0 of @3).
   bit sa_en, sa_val, cpl_en;
   int sa_addr, sa_bit;

   function automatic logic [7:0] rd_view(logic [7:0] v, int a);
      if (sa_en && a == sa_addr) v[sa_bit] = sa_val;
      return v;
   endfunction

   logic [7:0] mem0 [8];
   logic [7:0] mem1 [8];
   always @(posedge clk) begin
      if (b0.mem_we) begin
         mem0[b0.mem_addr] <= b0.mem_din;
         if (cpl_en && b0.mem_addr == 3'd2) mem0[3] <= mem0[3] ^ 8'h01;
      end else b0.mem_dout <= rd_view(mem0[b0.mem_addr], int'(b0.mem_addr));
   end
   always @(posedge clk) begin
      if (b1.mem_we) begin
         mem1[b1.mem_addr] <= b1.mem_din;
         if (cpl_en && b1.mem_addr == 3'd2) mem1[3] <= mem1[3] ^ 8'h01;
      end else b1.mem_dout <= rd_view(mem1[b1.mem_addr], int'(b1.mem_addr));
   end

   bit cur;
   logic o_we, o_busy, o_done, o_fail;
   logic [2:0] o_addr, o_fa;
   logic [7:0] o_din, o_fd;
   assign o_we   = cur ? b1.mem_we   : b0.mem_we;
   assign o_addr = cur ? b1.mem_addr : b0.mem_addr;
   assign o_din  = cur ? b1.mem_din  : b0.mem_din;
   assign o_busy = cur ? busy1 : busy0;
   assign o_done = cur ? done1 : done0;
   assign o_fail = cur ? fail1 : fail0;
   assign o_fa   = cur ? fa1 : fa0;
   assign o_fd   = cur ? fd1 : fd0;

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // March C- as a table indexed by element number (bit e = element Me).
   bit [5:0] e_down = 6'b011000;
   bit [5:0] e_rd   = 6'b111110;
   bit [5:0] e_wr   = 6'b011111;
   bit [5:0] e_rinv = 6'b010100;
   bit [5:0] e_winv = 6'b001010;

   typedef struct {bit we; int addr; logic [7:0] din;} op_t;
   op_t        eq[$];
   bit         ef;
   int         ea;
   logic [7:0] ed;

   task automatic build_ref(input logic [7:0] bg);
      logic [7:0] rm [8];
      logic [7:0] v, d;
      eq.delete();
      ef = 1'b0; ea = 0; ed = 8'h00;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 8; i++) begin
            int a;
            a = e_down[e] ? 7 - i : i;
            if (e_rd[e]) begin
               eq.push_back('{we: 1'b0, addr: a, din: 8'h00});
               v = rd_view(rm[a], a);
               if (v !== (e_rinv[e] ? ~bg : bg) && !ef) begin ef = 1'b1; ea = a; ed = v; end
            end
            if (e_wr[e]) begin
               d = e_winv[e] ? ~bg : bg;
               eq.push_back('{we: 1'b1, addr: a, din: d});
               rm[a] = d;
               if (cpl_en && a == 2) rm[3] = rm[3] ^ 8'h01;
            end
         end
      end
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start1 = v; else start0 = v;
   endtask

   // Start pulse sampled at E0; ops fill cycles 1..n, drain is n+1, done from n+2.
   task automatic run(input bit sel, input logic [7:0] bg, input bit mid_starts);
      int n;
      build_ref(bg);
      n = eq.size();
      cur = sel;
      @(negedge clk); set_start(sel, 1'b1);
      @(negedge clk); set_start(sel, 1'b0);
      for (int k = 1; k <= n + 2; k++) begin
         if (k == 1) begin
            chk("start_clears_done", 32'(o_done), 0);
            chk("start_clears_fail", 32'(o_fail), 0);
         end
         if (k <= n) begin
            chk($sformatf("busy_c%0d", k), 32'(o_busy), 1);
            chk($sformatf("we_c%0d", k), 32'(o_we), 32'(eq[k-1].we));
            chk($sformatf("addr_c%0d", k), 32'(o_addr), eq[k-1].addr);
            if (eq[k-1].we) chk($sformatf("din_c%0d", k), 32'(o_din), 32'(eq[k-1].din));
         end else if (k == n + 1) begin
            chk("drain_busy", 32'(o_busy), 1);
            chk("drain_we", 32'(o_we), 0);
            chk("drain_done", 32'(o_done), 0);
         end else begin
            chk("done", 32'(o_done), 1);
            chk("done_busy", 32'(o_busy), 0);
            chk("fail", 32'(o_fail), 32'(ef));
            if (ef) begin
               chk("fail_addr", 32'(o_fa), ea);
               chk("fail_data", 32'(o_fd), 32'(ed));
            end
         end
         set_start(sel, (mid_starts && (k == 10 || k == 30)) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
   endtask

   initial begin
      sa_en = 0; sa_val = 0; cpl_en = 0; sa_addr = 0; sa_bit = 0;
      start0 = 1'b0; start1 = 1'b0; cur = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_fail", 32'(fail0), 0);
      chk("rst_we", 32'(b0.mem_we), 0);
      chk("rst_addr", 32'(b0.mem_addr), 0);
      chk("rst_din", 32'(b0.mem_din), 0);
      chk("rst_fa", 32'(fa0), 0);
      chk("rst_fd", 32'(fd0), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", 32'(busy0), 0);
      chk("idle_we", 32'(b0.mem_we), 0);

      run(0, 8'h00, 0);

      sa_en = 1; sa_addr = 5; sa_bit = 3; sa_val = 1;
      run(0, 8'h00, 0);
      chk("sa_fail", 32'(fail0), 1);
      chk("sa_faddr", 32'(fa0), 5);
      chk("sa_fdata", 32'(fd0), 8'h08);

      sa_en = 0;
      run(0, 8'h00, 0);
      run(0, 8'h00, 1);

      // Asynchronous reset in the middle of M1 (cycle 20 is the write to address 5).
      sa_en = 1; sa_addr = 0; sa_bit = 0; sa_val = 1;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_rst_we", 32'(b0.mem_we), 1);
      chk("pre_rst_fail", 32'(fail0), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_we", 32'(b0.mem_we), 0);
      chk("arst_busy", 32'(busy0), 0);
      chk("arst_done", 32'(done0), 0);
      chk("arst_fail", 32'(fail0), 0);
      chk("arst_addr", 32'(b0.mem_addr), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", 32'(busy0), 0);
      chk("post_rst_we", 32'(b0.mem_we), 0);
      chk("post_rst_done", 32'(done0), 0);
      sa_en = 0;
      run(0, 8'h00, 0);

      for (int r = 0; r < 6; r++) begin
         sa_en = 1;
         sa_addr = int'($urandom_range(0, 7));
         sa_bit  = int'($urandom_range(0, 7));
         sa_val  = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run(0, 8'h00, 0);
      end
      sa_en = 0;

      run(1, 8'h55, 0);
      cpl_en = 1;
      run(1, 8'h55, 0);
      chk("cpl_fail", 32'(fail1), 1);
      chk("cpl_faddr", 32'(fa1), 3);
      cpl_en = 0;
      run(1, 8'h55, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
